// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package mem_arb_pkg;
    localparam int WORDSIZE    = 64;
    localparam int TAGWIDTH    = 13;
    localparam int BURST_BEATS = 8;
    localparam int BEAT_CNT_W  = $clog2(BURST_BEATS) + 1;

    localparam logic [WORDSIZE-1:0]   LINE_MASK = ~64'h3F;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_BEATS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} arb_state_e;
    typedef enum logic {I_CLIENT = 1'b0, D_CLIENT = 1'b1} client_e;

    function automatic logic [1:0] client_onehot(input client_e c);
        return (c == D_CLIENT) ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - cache-side and memory-side bus bundle for the arbiter
interface mem_bus_arbiter_if;
    import mem_arb_pkg::*;

    logic [1:0]                c_reqcyc;
    logic [1:0][WORDSIZE-1:0]  c_req;
    logic [1:0][TAGWIDTH-1:0]  c_reqtag;
    logic [1:0]                c_reqack;
    logic [1:0]                c_respcyc;
    logic [WORDSIZE-1:0]       c_resp;
    logic [TAGWIDTH-1:0]       c_resptag;
    logic [1:0]                c_respack;
    logic                      m_reqcyc;
    logic [WORDSIZE-1:0]       m_req;
    logic [TAGWIDTH-1:0]       m_reqtag;
    logic                      m_reqack;
    logic                      m_respcyc;
    logic [WORDSIZE-1:0]       m_resp;
    logic [TAGWIDTH-1:0]       m_resptag;
    logic                      m_respack;

    modport slave (
        input  c_reqcyc, c_req, c_reqtag, c_respack, m_reqack, m_respcyc, m_resp, m_resptag,
        output c_reqack, c_respcyc, c_resp, c_resptag, m_reqcyc, m_req, m_reqtag, m_respack
    );

    modport master (
        output c_reqcyc, c_req, c_reqtag, c_respack, m_reqack, m_respcyc, m_resp, m_resptag,
        input  c_reqack, c_respcyc, c_resp, c_resptag, m_reqcyc, m_req, m_reqtag, m_respack
    );
endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// rtl/mem_bus_arbiter_rr.sv - two-way round-robin grant decision
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  client_e    last,
    output logic       gnt_valid,
    output client_e    gnt_id
);

    // A lone requester wins; a tie goes to the client not granted last
    always_comb begin
        gnt_valid = |req;
        gnt_id    = I_CLIENT;
        if (req == 2'b11) begin
            gnt_id = (last == I_CLIENT) ? D_CLIENT : I_CLIENT;
        end else if (req[1]) begin
            gnt_id = D_CLIENT;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the memory bus between I$ and D$ line fills
module mem_bus_arbiter
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);

    arb_state_e              state, state_nxt;
    client_e                 grant, last_grant, gnt_id;
    logic                    gnt_valid;
    logic                    grant_now;
    logic                    route;
    logic                    xfer;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [1:0]              reqack_q;
    logic                    reqcyc_q;
    logic [WORDSIZE-1:0]     req_q;
    logic [TAGWIDTH-1:0]     reqtag_q;

    rr_arbiter2 u_rr (
        .req       (bus.c_reqcyc),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Next-state decode; beat routing is live in BURST and held through DRAIN
    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        route     = (state == BURST) || (state == DRAIN);
        xfer      = (state == BURST) && bus.m_respcyc && bus.c_respack[grant];
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant_now = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_reqack) state_nxt = BURST;
            end
            BURST: begin
                if (xfer && (beat_cnt == LAST_BEAT)) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant latch, request issue registers and beat counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= I_CLIENT;
            last_grant <= D_CLIENT;
            beat_cnt   <= '0;
            reqack_q   <= '0;
            reqcyc_q   <= 1'b0;
            req_q      <= '0;
            reqtag_q   <= '0;
        end else begin
            reqack_q <= '0;
            if (grant_now) begin
                grant      <= gnt_id;
                last_grant <= gnt_id;
                reqack_q   <= client_onehot(gnt_id);
                reqcyc_q   <= 1'b1;
                req_q      <= bus.c_req[gnt_id] & LINE_MASK;
                reqtag_q   <= bus.c_reqtag[gnt_id];
            end
            if ((state == ISSUE) && bus.m_reqack) begin
                reqcyc_q <= 1'b0;
                beat_cnt <= '0;
            end
            if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign bus.c_reqack  = reqack_q;
    assign bus.m_reqcyc  = reqcyc_q;
    assign bus.m_req     = req_q;
    assign bus.m_reqtag  = reqtag_q;
    assign bus.c_respcyc = route ? (client_onehot(grant) & {2{bus.m_respcyc}}) : 2'b00;
    assign bus.c_resp    = route ? bus.m_resp : '0;
    assign bus.c_resptag = route ? bus.m_resptag : '0;
    assign bus.m_respack = (state == BURST) && bus.c_respack[grant];

endmodule
